// File: rtl/qam16_ctrl_pkg.sv
// Shared types and constants for the QAM16 loopback frame controller.
// State encoding, preamble symbols and the delay-line entry layout.
package qam16_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    PAY   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] PRE_SYM_A = 4'h0;
  localparam logic [3:0] PRE_SYM_B = 4'hF;

  typedef struct packed {
    logic       tag;
    logic [3:0] sym;
  } dl_ent_t;

endpackage

// File: rtl/qam16_sym_delay.sv
// DEPTH-deep {tag, sym} shift register aligning TX symbols with RX.
// Ports: clk, reset (sync, active-low), en (shift), clr (sync clear),
// din (entry in), dout (entry shifted in DEPTH enables ago).
module qam16_sym_delay
  import qam16_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    clr,
  input  dl_ent_t din,
  output dl_ent_t dout
);

  dl_ent_t dl [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      for (int i = 0; i < DEPTH; i++)
        dl[i] <= '0;
    end else if (en) begin
      dl[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        dl[i] <= dl[i-1];
    end
  end

  assign dout = dl[DEPTH-1];

endmodule

// File: rtl/qam16_frame_ctrl.sv
// Frame scheduler for the QAM16 loopback chain: phase counter, strobes,
// PRE/PAY/FLUSH sequencing, TX symbol mux and payload error counting.
// Ports: clk, reset (sync, active-low), start, continuous, smp_phase,
// tx_data, rx_data in; phase_cnt, sym_stb, smp_stb, prbs_en, tx_sym,
// busy, frame_done, sym_err, err_cnt out.
module qam16_frame_ctrl
  import qam16_ctrl_pkg::*;
#(
  parameter int OSR     = 4,
  parameter int CNT_W   = 4,
  parameter int PRE_LEN = 8,
  parameter int PAY_LEN = 32,
  parameter int RX_LAT  = 2,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [CNT_W-1:0] smp_phase,
  input  logic [3:0]       tx_data,
  input  logic [3:0]       rx_data,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             sym_stb,
  output logic             smp_stb,
  output logic             prbs_en,
  output logic [3:0]       tx_sym,
  output logic             busy,
  output logic             frame_done,
  output logic             sym_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int MAX_A =
    (PRE_LEN > PAY_LEN) ? PRE_LEN : PAY_LEN;
  localparam int MAX_LEN =
    (MAX_A > RX_LAT) ? MAX_A : RX_LAT;
  localparam int IDX_W = $clog2(MAX_LEN + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] phase_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [ERR_W-1:0] err_n;
  logic             wrap;
  logic             last_sym;
  logic             dl_clr;
  dl_ent_t          dl_in, dl_out;

  assign busy    = (state != IDLE);
  assign sym_stb = busy && (phase_cnt == '0);
  assign smp_stb = busy && (phase_cnt == smp_phase);
  assign prbs_en = sym_stb && (state == PAY);
  assign wrap    = busy &&
    (phase_cnt == CNT_W'(OSR - 1));

  always_comb begin
    tx_sym = 4'h0;
    unique case (state)
      PRE:     tx_sym = idx[0] ? PRE_SYM_B
                               : PRE_SYM_A;
      PAY:     tx_sym = tx_data;
      default: tx_sym = 4'h0;
    endcase
  end

  always_comb begin
    last_sym = 1'b0;
    unique case (state)
      PRE:     last_sym =
        (idx == IDX_W'(PRE_LEN - 1));
      PAY:     last_sym =
        (idx == IDX_W'(PAY_LEN - 1));
      FLUSH:   last_sym =
        (idx == IDX_W'(RX_LAT - 1));
      default: last_sym = 1'b0;
    endcase
  end

  // A fresh frame from IDLE must not compare stale entries.
  assign dl_clr    = (state == IDLE) && start;
  assign dl_in.tag = (state == PAY);
  assign dl_in.sym = tx_sym;

  qam16_sym_delay #(
    .DEPTH (RX_LAT)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .en    (sym_stb),
    .clr   (dl_clr),
    .din   (dl_in),
    .dout  (dl_out)
  );

  assign sym_err = sym_stb && dl_out.tag &&
    (dl_out.sym != rx_data);

  always_comb begin
    state_n    = state;
    phase_n    = phase_cnt;
    idx_n      = idx;
    err_n      = err_cnt;
    frame_done = 1'b0;
    if (sym_err && (err_cnt != '1))
      err_n = err_cnt + ERR_W'(1);
    if (state == IDLE) begin
      phase_n = '0;
      idx_n   = '0;
      if (start) begin
        state_n = PRE;
        err_n   = '0;
      end
    end else if (wrap) begin
      phase_n = '0;
      if (last_sym) begin
        idx_n = '0;
        unique case (state)
          PRE: state_n = PAY;
          PAY: state_n = FLUSH;
          FLUSH: begin
            frame_done = 1'b1;
            if (continuous) begin
              state_n = PRE;
              err_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end else begin
        idx_n = idx + IDX_W'(1);
      end
    end else begin
      phase_n = phase_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      idx       <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      phase_cnt <= phase_n;
      idx       <= idx_n;
      err_cnt   <= err_n;
    end
  end

endmodule

// File: tb/tb_qam16_frame_ctrl.sv
// Bench for qam16_frame_ctrl: frame-time reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_qam16_frame_ctrl;

  localparam int OSR     = 4;
  localparam int CNT_W   = 4;
  localparam int PRE_LEN = 8;
  localparam int PAY_LEN = 32;
  localparam int RX_LAT  = 2;
  localparam int FRAME   = (PRE_LEN + PAY_LEN + RX_LAT) * OSR;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic [CNT_W-1:0] smp_phase = 4'd2;
  logic [3:0]       tx_data = 4'h0;
  logic [3:0]       rx_data = 4'h0;

  logic [CNT_W-1:0] phase_cnt;
  logic             sym_stb, smp_stb, prbs_en;
  logic [3:0]       tx_sym;
  logic             busy, frame_done, sym_err;
  logic [7:0]       err_cnt;

  logic [CNT_W-1:0] s_phase_cnt;
  logic             s_sym_stb, s_smp_stb, s_prbs_en;
  logic [3:0]       s_tx_sym;
  logic             s_busy, s_frame_done, s_sym_err;
  logic [3:0]       s_err_cnt;

  qam16_frame_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .smp_phase  (smp_phase),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .phase_cnt  (phase_cnt),
    .sym_stb    (sym_stb),
    .smp_stb    (smp_stb),
    .prbs_en    (prbs_en),
    .tx_sym     (tx_sym),
    .busy       (busy),
    .frame_done (frame_done),
    .sym_err    (sym_err),
    .err_cnt    (err_cnt)
  );

  qam16_frame_ctrl #(.ERR_W(4)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .smp_phase  (smp_phase),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .phase_cnt  (s_phase_cnt),
    .sym_stb    (s_sym_stb),
    .smp_stb    (s_smp_stb),
    .prbs_en    (s_prbs_en),
    .tx_sym     (s_tx_sym),
    .busy       (s_busy),
    .frame_done (s_frame_done),
    .sym_err    (s_sym_err),
    .err_cnt    (s_err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: position within the frame in cycles.
  bit chk_en = 0;
  bit m_busy = 0;
  int m_t    = 0;
  int m_raw  = 0;
  int hist [0:63];

  int e_s, e_ph, e_phase, e_tx, e_err, e_serr_cnt, jj;
  bit e_sym, e_smp, e_prbs, e_fd, e_serr, e_pay;

  always_comb begin
    e_s     = m_t / OSR;
    e_ph    = m_t % OSR;
    e_phase = m_busy ? e_ph : 0;
    e_sym   = m_busy && (e_ph == 0);
    e_smp   = m_busy && (e_ph == int'(smp_phase));
    e_pay   = m_busy && (e_s >= PRE_LEN) &&
              (e_s < PRE_LEN + PAY_LEN);
    e_prbs  = e_sym && e_pay;
    e_tx    = 0;
    if (m_busy && e_s < PRE_LEN) e_tx = (e_s % 2) ? 15 : 0;
    else if (e_pay) e_tx = int'(tx_data);
    e_fd    = m_busy && (m_t == FRAME - 1);
    jj      = e_s - RX_LAT;
    e_serr  = 1'b0;
    if (e_sym && jj >= PRE_LEN && jj < PRE_LEN + PAY_LEN)
      e_serr = (int'(rx_data) != hist[jj]);
    e_err      = (m_raw > 255) ? 255 : m_raw;
    e_serr_cnt = (m_raw > 15) ? 15 : m_raw;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 0;
      m_t    <= 0;
      m_raw  <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1;
        m_t    <= 0;
        m_raw  <= 0;
      end
    end else begin
      if (e_sym) hist[e_s] <= e_tx;
      if (m_t == FRAME - 1) begin
        if (continuous) begin
          m_t   <= 0;
          m_raw <= 0;
        end else begin
          m_busy <= 0;
          m_raw  <= m_raw + (e_serr ? 1 : 0);
        end
      end else begin
        m_t   <= m_t + 1;
        m_raw <= m_raw + (e_serr ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase_cnt", int'(phase_cnt), e_phase);
      chk("sym_stb", int'(sym_stb), int'(e_sym));
      chk("smp_stb", int'(smp_stb), int'(e_smp));
      chk("prbs_en", int'(prbs_en), int'(e_prbs));
      chk("tx_sym", int'(tx_sym), e_tx);
      chk("busy", int'(busy), int'(m_busy));
      chk("frame_done", int'(frame_done), int'(e_fd));
      chk("sym_err", int'(sym_err), int'(e_serr));
      chk("err_cnt", int'(err_cnt), e_err);
      chk("sat_sym_err", int'(s_sym_err), int'(e_serr));
      chk("sat_err_cnt", int'(s_err_cnt), e_serr_cnt);
    end
  end

  // Chain emulation: PRBS source and RX_LAT-symbol loopback.
  bit         inj_en   = 0;
  bit         rx_zero  = 0;
  bit         force_nz = 0;
  logic [7:0] lfsr     = 8'hA5;
  logic [3:0] lb0      = 4'h0;
  logic [3:0] lb1      = 4'h0;

  initial begin
    bit         c_stb, c_pe, inj;
    logic [3:0] c_tx;
    int         s;
    forever begin
      @(negedge clk);
      c_stb = sym_stb;
      c_pe  = prbs_en;
      c_tx  = tx_sym;
      @(posedge clk);
      #1;
      if (c_stb) begin
        lb1 = lb0;
        lb0 = c_tx;
      end
      if (c_pe)
        lfsr = {lfsr[6:0],
                lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      tx_data = force_nz ? (lfsr[3:0] | 4'h1) : lfsr[3:0];
      s   = m_t / OSR;
      inj = inj_en && m_busy &&
            (s == PRE_LEN + 4 + RX_LAT ||
             s == PRE_LEN + 19 + RX_LAT);
      rx_data = rx_zero ? 4'h0 : (lb1 ^ {3'b000, inj});
    end
  end

  int pe_n, pe_first, pe_last, fd_at, fd_n;
  int err_fd, serr_n, busy1, busy_end, nz_n, s_err_fd;

  task automatic run_frame(input int ncyc);
    pe_n = 0; pe_first = 0; pe_last = 0; fd_at = 0; fd_n = 0;
    err_fd = -1; serr_n = 0; busy1 = 0; busy_end = 1;
    nz_n = 0; s_err_fd = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = int'(busy);
      if (prbs_en) begin
        pe_n++;
        if (pe_first == 0) pe_first = k;
        pe_last = k;
        if (tx_data != 4'h0) nz_n++;
      end
      if (frame_done) begin
        fd_n++;
        if (fd_at == 0) fd_at = k;
        err_fd   = int'(err_cnt);
        s_err_fd = int'(s_err_cnt);
      end
      if (sym_err) serr_n++;
      if (k == FRAME + 1) busy_end = int'(busy);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int any, idle_n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1;

    // Idle after reset
    any = 0;
    repeat (20) begin
      @(negedge clk);
      any += int'(busy) + int'(sym_stb) + int'(smp_stb) +
             int'(prbs_en) + int'(frame_done) + int'(sym_err) +
             int'(tx_sym) + int'(err_cnt) + int'(phase_cnt);
    end
    chk("idle_outputs", any, 0);
    @(posedge clk); #1;

    // Clean loopback frame
    run_frame(FRAME + 4);
    chk("busy_rise", busy1, 1);
    chk("prbs_count", pe_n, 32);
    chk("prbs_first", pe_first, 33);
    chk("prbs_last", pe_last, 157);
    chk("frame_done_at", fd_at, 168);
    chk("frame_done_n", fd_n, 1);
    chk("err_clean", err_fd, 0);
    chk("busy_after", busy_end, 0);

    // Two injected payload errors
    smp_phase = 4'd0;
    inj_en = 1;
    run_frame(FRAME + 4);
    inj_en = 0;
    chk("inj_sym_err_n", serr_n, 2);
    chk("inj_err_cnt", err_fd, 2);

    // RX stuck at zero over PRBS payload
    smp_phase = 4'd3;
    rx_zero = 1;
    run_frame(FRAME + 4);
    chk("zero_err_vs_nz", err_fd, nz_n);
    // All-mismatch payload: 32 errors, narrow counter saturates
    force_nz = 1;
    run_frame(FRAME + 4);
    chk("allmis_err", err_fd, 32);
    chk("allmis_sat", s_err_fd, 15);
    rx_zero = 0;
    force_nz = 0;

    // Continuous frames with an ignored start while busy
    continuous = 1;
    inj_en = 1;
    fd_n = 0; idle_n = 0; any = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      if (frame_done) fd_n++;
      if (!busy) idle_n++;
      if (k == FRAME + 1) any = int'(err_cnt);
      if (k == 2 * FRAME) err_fd = int'(err_cnt);
      @(posedge clk); #1;
      if (k == 100) start = 1'b1;
      if (k == 101) start = 1'b0;
      if (k == 150) smp_phase = 4'd1;
    end
    chk("cont_fd_n", fd_n, 2);
    chk("cont_no_idle", idle_n, 0);
    chk("cont_err_clr", any, 0);
    chk("cont_err_2nd", err_fd, 2);
    continuous = 0;
    fd_n = 0;
    for (int k = 0; k < FRAME + 8 && busy; k++) begin
      @(negedge clk);
      if (frame_done) fd_n++;
      @(posedge clk); #1;
    end
    chk("cont_stop_idle", int'(busy), 0);
    chk("cont_stop_fd", fd_n, 1);

    // Reset mid-payload
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (59) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    inj_en = 0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_phase", int'(phase_cnt), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_fd", int'(frame_done), 0);
    @(posedge clk); #1;
    run_frame(FRAME + 4);
    chk("post_rst_fd_at", fd_at, 168);
    chk("post_rst_fd_n", fd_n, 1);
    chk("post_rst_busy", busy_end, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
